// File: rtl/iram_loader.sv
// Monitor-side loader/dumper for the instruction RAM: packs an rx byte stream into words, or streams words out as tx bytes.
// Optional running byte checksum is built when IRAM_LOADER_CHKSUM_EN is defined.
module iram_loader #(
  parameter int IADR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_load,
  input  logic              cmd_dump,
  input  logic [IADR_W-1:0] start_wadr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [IADR_W-1:0] i_ram_wadr,
  output logic [31:0]       i_ram_wdata,
  output logic              i_ram_wen,
  output logic [IADR_W-1:0] i_ram_radr,
  input  logic [31:0]       i_ram_rdata,
  output logic              i_read_sel,
  output logic              busy,
  output logic              done,
  output logic [7:0]        chksum
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, RD_ADR, RD_WAIT, SEND, FIN
  } state_t;

  state_t              state_q, state_d;
  logic [IADR_W-1:0]   adr_q, adr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // One shift register serves both directions: load shifts bytes in at the top, dump shifts them out at the bottom.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (cmd_load || cmd_dump) begin
          adr_d = start_wadr;
          rem_d = word_count;
          idx_d = '0;
          if (word_count == '0)
            state_d = FIN;
          else if (cmd_load)
            state_d = LOAD;
          else
            state_d = RD_ADR;
        end
      end
      LOAD: begin
        if (rx_valid) begin
          shift_d = {rx_data, shift_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_d = WRITE;
        end
      end
      WRITE: begin
        adr_d   = adr_q + IADR_W'(1);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? FIN : LOAD;
      end
      RD_ADR: state_d = RD_WAIT;
      RD_WAIT: begin
        shift_d = i_ram_rdata;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          shift_d = {8'h00, shift_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            adr_d   = adr_q + IADR_W'(1);
            rem_d   = rem_q - CNT_W'(1);
            state_d = (rem_q == CNT_W'(1)) ? FIN : RD_ADR;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign i_ram_wen   = (state_q == WRITE);
  assign i_ram_wadr  = adr_q;
  assign i_ram_wdata = shift_q;
  assign i_ram_radr  = adr_q;
  assign i_read_sel  = (state_q == RD_ADR) || (state_q == RD_WAIT) || (state_q == SEND);
  assign tx_valid    = (state_q == SEND);
  assign tx_data     = shift_q[7:0];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);

`ifdef IRAM_LOADER_CHKSUM_EN
  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == IDLE && (cmd_load || cmd_dump))
      chk_d = '0;
    else if (state_q == LOAD && rx_valid)
      chk_d = chk_q + rx_data;
    else if (state_q == SEND && tx_ready)
      chk_d = chk_q + shift_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign chksum = chk_q;
`else
  assign chksum = 8'h00;
`endif

endmodule

// File: doc/iram_loader.md
Name: iram_loader

Overview:
- Monitor-side writer and dumper for the instruction RAM, sitting on the opposite side of the i_ram write/read-back port used by the fetch stage.
- Load mode takes a byte stream (e.g. from the UART receiver), packs it into 32-bit words little-endian, and writes them to consecutive word addresses.
- Dump mode takes over the read port with i_read_sel and streams RAM words back out as bytes through a valid/ready transmit handshake.

Parameters:
- IADR_W, 10, word-address width of the instruction RAM (address bits [11:2]).
- CNT_W, 11, width of the word-count input; allows 0..1024 words.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cmd_load  input  1  one-cycle pulse: start a load
- cmd_dump  input  1  one-cycle pulse: start a dump
- start_wadr  input  IADR_W  first word address for load or dump
- word_count  input  CNT_W  number of words to transfer
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid, one cycle per byte
- tx_data  output  8  outgoing byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  consumer accepts tx_data
- i_ram_wadr  output  IADR_W  RAM write word address
- i_ram_wdata  output  32  RAM write data
- i_ram_wen  output  1  RAM write enable
- i_ram_radr  output  IADR_W  RAM read word address
- i_ram_rdata  input  32  RAM read data, valid 1 cycle after i_ram_radr
- i_read_sel  output  1  steers the RAM read port to this block
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at end of a transfer
- chksum  output  8  byte checksum (see Optional Feature)

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset rst is synchronous and active-high.
  - Reset clears every output to 0 (tx_data, tx_valid, i_ram_*, i_read_sel, busy, done, chksum) and returns the FSM to IDLE.
- States: IDLE, LOAD, WRITE, RD_ADR, RD_WAIT, SEND, FIN.
- IDLE:
  - cmd_load goes to LOAD; cmd_dump goes to RD_ADR. If both are asserted, cmd_load wins.
  - On the start command, latch start_wadr into the address counter and word_count into the remaining-words counter, and clear the byte index.
  - If word_count == 0, go directly to FIN.
  - Commands are ignored when not in IDLE.
- LOAD:
  - Each rx_valid places rx_data into byte lane idx: the first byte goes to [7:0], the fourth to [31:24]. idx then increments.
  - On the 4th byte, go to WRITE.
  - rx_valid is ignored in every state except LOAD. A byte arriving in the WRITE cycle is dropped; the sender must allow at least 1 idle cycle between words.
- WRITE:
  - i_ram_wen is high for exactly one cycle, with i_ram_wadr = address counter and i_ram_wdata = assembled word.
  - The address counter increments modulo 2^IADR_W (1023 wraps to 0), and remaining decrements.
  - If remaining reaches 0, go to FIN; otherwise return to LOAD.
- Dump path:
  - i_read_sel is high throughout RD_ADR, RD_WAIT and SEND, and low otherwise.
  - RD_ADR drives i_ram_radr = address counter.
  - RD_WAIT lasts one cycle; at its end, capture i_ram_rdata into the shift register.
  - SEND: tx_valid = 1 and tx_data = shift[7:0]. On tx_valid & tx_ready, shift right by 8 and increment idx.
  - After 4 accepted bytes: increment the address (same wrap rule), decrement remaining, then go to RD_ADR or, if remaining is 0, to FIN.
  - tx_data is held stable while tx_valid & !tx_ready.
- FIN: done = 1 for one cycle, then go to IDLE.
- Reset mid-operation:
  - Any partial word is discarded and i_ram_wen is low from the next edge onward.
  - A pending tx byte is dropped.
- Latency:
  - Load: WRITE follows the 4th rx byte by 1 cycle.
  - Dump: the first tx_valid is asserted 3 cycles after cmd_dump.

Optional Feature:
- Macro: IRAM_LOADER_CHKSUM_EN.
- When defined:
  - chksum is an 8-bit modulo-256 sum of every byte accepted in LOAD and every byte accepted (tx handshake) in SEND.
  - It is cleared on any accepted start command and on rst.
  - It is held after done.
- When not defined: chksum is tied to 8'h00 and no accumulator logic exists.

Test Plan:
- Load 1 word: start_wadr=0x010, count=1, rx bytes 0x13,0x05,0x10,0x00 → single i_ram_wen cycle with wadr=0x010, wdata=0x00100513; done pulses 1 cycle later; chksum=0x28 if enabled.
- Wrap: start_wadr=0x3FF, count=2, words 0xAAAAAAAA then 0x55555555 → writes at 0x3FF then 0x000; busy stays high from the cycle after cmd_load until done.
- Dump with backpressure: RAM[0x020]=0x12345678, count=1, tx_ready low for 3 cycles then high → tx_data holds 0x78 while stalled, then 0x56,0x34,0x12; i_read_sel high only during the dump; done pulses once.
- Simultaneous commands: cmd_load and cmd_dump in the same cycle → load performed, i_read_sel stays 0; cmd_dump while busy is ignored.
- word_count=0 → done 1 cycle after the command, no i_ram_wen, no tx_valid.
- Reset mid-load after 2 bytes, then a new load of 0xDEADBEEF at 0x005 → only 0xDEADBEEF is written to 0x005; no stale bytes appear.
